pc_conf_router: RTL

//  Successor to the PC config mapper. Accepts one host config word per handshake from the PC parser and routes it.

---
 rtl/pc_conf_router.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pc_conf_router.sv
// ============================================================================
// Module   : pc_conf_router
// Brief    : Routes host config words into a staged register bank or onto
//            per-channel deserializers that assemble CHAN_W-wide words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_conf_router #(
  parameter int Nconf  = 16,
  parameter int Nreg   = 64,
  parameter int Nchan  = 4,
  parameter int CHAN_W = 51,
  parameter int STAGED = 1,
  parameter logic [Nreg-1:0][Nconf-1:0] RESET_VALS = '0,
  parameter int AW     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_v,
  output logic                      in_a,
  input  logic                      in_kind,
  input  logic [AW-1:0]             in_addr,
  input  logic [Nconf-1:0]          in_d,
  output logic [Nreg*Nconf-1:0]     conf_reg,
  output logic [Nchan-1:0]          out_v,
  output logic [Nchan*CHAN_W-1:0]   out_d,
  input  logic [Nchan-1:0]          out_a,
  output logic                      commit_pulse,
  output logic [7:0]                bad_addr_ct
);

  localparam int C_NCHUNK = (CHAN_W + Nconf - 1) / Nconf;
  localparam int C_CW     = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
  localparam int C_ASM_W  = (C_NCHUNK > 1) ? (C_NCHUNK - 1) * Nconf : 1;
  localparam logic [C_CW-1:0] C_LAST  = C_CW'(C_NCHUNK - 1);
  localparam logic [31:0]     C_NREG  = 32'(Nreg);
  localparam logic [31:0]     C_NCHAN = 32'(Nchan);

  logic [31:0]                  w_addr;
  logic                         w_is_commit;
  logic                         w_reg_wr;
  logic                         w_commit;
  logic                         w_bad;
  logic [Nchan-1:0]             w_sel;
  logic [Nchan-1:0]             w_ready;
  logic [Nchan-1:0]             w_take;
  logic [Nreg-1:0][Nconf-1:0]   r_live;
  logic [7:0]                   r_bad_ct;

  assign w_addr      = 32'(in_addr);
  assign w_is_commit = ~in_kind & (w_addr == C_NREG);
  assign w_reg_wr    = in_v & ~in_kind & (w_addr < C_NREG);
  assign w_commit    = in_v & w_is_commit & (STAGED != 0);
  // COMMIT address is only meaningful with a shadow bank; otherwise it is bad
  assign w_bad       = in_v & (in_kind ? (w_addr >= C_NCHAN)
                                       : ((w_addr > C_NREG) | (w_is_commit & (STAGED == 0))));

  // Only a full channel whose pending word is not being taken can stall the input
  assign in_a = ~|(w_sel & ~w_ready);

  assign conf_reg    = r_live;
  assign bad_addr_ct = r_bad_ct;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bad_ct <= 8'd0;
    end else if (w_bad && (r_bad_ct != 8'hFF)) begin
      r_bad_ct <= r_bad_ct + 8'd1;
    end
  end

  generate
    if (STAGED != 0) begin : g_staged
      logic [Nreg-1:0][Nconf-1:0] r_shadow;
      logic                       r_commit_pulse;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_shadow <= RESET_VALS;
        end else begin
          for (int r = 0; r < Nreg; r++) begin
            if (w_reg_wr && (w_addr == 32'(r))) begin
              r_shadow[r] <= in_d;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_live         <= RESET_VALS;
          r_commit_pulse <= 1'b0;
        end else begin
          r_commit_pulse <= w_commit;
          if (w_commit) begin
            r_live <= r_shadow;
          end
        end
      end

      assign commit_pulse = r_commit_pulse;
    end else begin : g_direct
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_live <= RESET_VALS;
        end else begin
          for (int r = 0; r < Nreg; r++) begin
            if (w_reg_wr && (w_addr == 32'(r))) begin
              r_live[r] <= in_d;
            end
          end
        end
      end

      assign commit_pulse = 1'b0;
    end
  endgenerate

  generate
    for (genvar c = 0; c < Nchan; c++) begin : g_chan
      logic [C_CW-1:0]    r_cnt;
      logic               r_out_v;
      logic [CHAN_W-1:0]  r_out_d;
      logic [C_ASM_W-1:0] r_asm;
      logic [CHAN_W-1:0]  w_word;

      assign w_sel[c]   = in_kind & (w_addr == 32'(c));
      assign w_ready[c] = (r_cnt != C_LAST) | ~r_out_v | out_a[c];
      assign w_take[c]  = in_v & w_sel[c] & w_ready[c];

      // Last chunk comes straight from the input; its bits above CHAN_W are dropped
      assign w_word = (C_NCHUNK > 1) ? CHAN_W'({in_d, r_asm}) : CHAN_W'(in_d);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt   <= '0;
          r_out_v <= 1'b0;
          r_out_d <= '0;
          r_asm   <= '0;
        end else begin
          if (out_a[c]) begin
            r_out_v <= 1'b0;
          end
          if (w_take[c]) begin
            if (r_cnt == C_LAST) begin
              r_out_d <= w_word;
              r_out_v <= 1'b1;
              r_cnt   <= '0;
            end else begin
              for (int i = 0; i < C_ASM_W; i++) begin
                if (C_CW'(i / Nconf) == r_cnt) begin
                  r_asm[i] <= in_d[i % Nconf];
                end
              end
              r_cnt <= r_cnt + C_CW'(1);
            end
          end
        end
      end

      assign out_v[c]                    = r_out_v;
      assign out_d[c*CHAN_W +: CHAN_W]   = r_out_d;
    end
  endgenerate

endmodule

`default_nettype wire
